generator_krokow: RTL
=====================

// Module: generator_krokow
// PURPOSE
//  Step/direction pulse generator downstream of zmiana_rpm, inside glowny_sterownik_silnika.
//  Latches the rpm set-point on each sygnal_zmiany_rpm strobe and ramps the actual speed toward it.
//  Emits fixed-width krok pulses at an exact average rate of biezace_rpm*STEPS_PER_REV/60 Hz.
//  Handles direction reversal safely: decelerate to 0, flip kier, accelerate.
// PARAMETERS
//  CLK_HZ         50_000_000  clk frequency in Hz
//  STEPS_PER_REV  200         motor steps per revolution
//  RPM_MAX        100         set-point clamp, <=127
//  RAMP_TICKS     500_000     clocks per 1-rpm speed change during ramp
//  PULSE_W        100         krok high time in clocks; must be < CLK_HZ*60/(RPM_MAX*STEPS_PER_REV)/2
// PORTS
//  clk                in   1  system clock, all logic on rising edge
//  rst                in   1  synchronous, active-high reset
//  rpm                in   7  requested speed, sampled only on strobe
//  sygnal_zmiany_rpm  in   1  1-clk strobe: latch rpm and kierunek
//  kierunek           in   1  requested direction, sampled only on strobe
//  krok               out  1  step pulse, PULSE_W clocks high
//  kier               out  1  direction to driver
//  biezace_rpm        out  7  current (ramped) speed
//  w_ruchu            out  1  1 while biezace_rpm != 0
//  gotowy             out  1  1 when biezace_rpm==target and kier==target direction
// BEHAVIOUR
//  Reset: krok=0, kier=0, biezace_rpm=0, w_ruchu=0, gotowy=1; target=0, target_dir=0, acc=0, timers=0.
//  Reset mid-operation: krok drops at the next edge; no pulse is completed.
//  Strobe: target <= min(rpm, RPM_MAX); target_dir <= kierunek. Same values again: no effect, timers keep running.
//  Step rate: 33-bit acc; each clk acc += biezace_rpm*STEPS_PER_REV. When acc >= CLK_HZ*60:
//   acc -= CLK_HZ*60 and a step is issued (krok rises on the next clk). acc is cleared while biezace_rpm==0.
//  krok high exactly PULSE_W clocks. Parameter constraint guarantees no step becomes due while krok is high.
//  FSM states: STOP, ACCEL, RUN, DECEL, REVERSE.
//   STOP:    biezace_rpm==0. target!=0 -> REVERSE if target_dir!=kier, else ACCEL.
//   ACCEL:   +1 rpm every RAMP_TICKS clocks; ==target -> RUN; target below current -> DECEL.
//   RUN:     target>current -> ACCEL; target<current or dir mismatch -> DECEL.
//   DECEL:   -1 rpm every RAMP_TICKS clocks, toward 0 on dir mismatch, else toward target.
//            Reaching target -> RUN; reaching 0 -> REVERSE on dir mismatch, else STOP.
//   REVERSE: wait until krok==0, set kier=target_dir, hold PULSE_W clocks (no steps) -> ACCEL or STOP.
//  Ramp timer: counts 0..RAMP_TICKS-1 while a change is pending; cleared in RUN/STOP/REVERSE.
//   The first change occurs RAMP_TICKS clocks after the strobe that was accepted.
//  gotowy and w_ruchu are registered and updated in the same cycle as biezace_rpm.
//  rpm=0 target: ramps down to 0, krok stays low afterwards, kier is held.
// CONFIGURATION
//  KROK_RAMPA_EN defined: ramped behaviour as above.
//  KROK_RAMPA_EN undefined: no ramp. biezace_rpm = target on the clk after the strobe (ACCEL/DECEL skipped).
//   A dir mismatch goes through REVERSE with biezace_rpm forced to 0 for its duration.
// TESTING (CLK_HZ=1000, STEPS_PER_REV=6, RAMP_TICKS=20, PULSE_W=4, RPM_MAX=100)
//  1. Hold rst 3 clks -> krok=0, kier=0, biezace_rpm=0, w_ruchu=0, gotowy=1.
//  2. Strobe rpm=10, kierunek=0 -> biezace_rpm +1 every 20 clks, reaches 10 after 200 clks, gotowy=1.
//     Steady state: krok period 1000 clks, high for 4 clks.
//  3. Strobe rpm=120 -> target clamps to 100. At 100 rpm: krok period 100 clks; no pulse overlaps another.
//  4. At 10 rpm, strobe rpm=10, kierunek=1 -> ramps to 0, kier=1, 4 clks with no krok, ramps back to 10.
//     gotowy=0 throughout until 10 rpm is reached in the new direction.
//  5. Assert rst during a krok high pulse -> krok=0 on the next edge; all outputs take reset values.
//  6. KROK_RAMPA_EN undefined: strobe rpm=10 -> biezace_rpm=10 one clk later; krok period 1000 clks.

Source files
------------

// File: rtl/generator_krokow_if.sv
// rtl/generator_krokow_if.sv - command and step/direction signal bundle for generator_krokow
//   master: drives rpm, sygnal_zmiany_rpm, kierunek; observes krok, kier, biezace_rpm, w_ruchu, gotowy
//   slave : the generator side of the same bundle
interface generator_krokow_if;
    logic [6:0] rpm;
    logic       sygnal_zmiany_rpm;
    logic       kierunek;
    logic       krok;
    logic       kier;
    logic [6:0] biezace_rpm;
    logic       w_ruchu;
    logic       gotowy;

    modport master (
        output rpm, sygnal_zmiany_rpm, kierunek,
        input  krok, kier, biezace_rpm, w_ruchu, gotowy
    );

    modport slave (
        input  rpm, sygnal_zmiany_rpm, kierunek,
        output krok, kier, biezace_rpm, w_ruchu, gotowy
    );
endinterface

// File: rtl/generator_krokow.sv
// rtl/generator_krokow.sv - step/direction pulse generator with speed ramp and safe reversal
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : generator_krokow_if.slave
//          rpm/kierunek latched on sygnal_zmiany_rpm; krok pulses, kier direction,
//          biezace_rpm current speed, w_ruchu moving flag, gotowy settled flag
//   KROK_RAMPA_EN defined: speed ramps 1 rpm per RAMP_TICKS clocks
//   KROK_RAMPA_EN undefined: speed jumps to the set-point one clock after the strobe
module generator_krokow #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned STEPS_PER_REV = 200,
    parameter int unsigned RPM_MAX       = 100,
    parameter int unsigned RAMP_TICKS    = 500_000,
    parameter int unsigned PULSE_W       = 100
) (
    input  logic               clk,
    input  logic               rst,
    generator_krokow_if.slave  bus
);

`ifdef KROK_RAMPA_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    // One step is due each time the accumulator passes CLK_HZ*60, which gives
    // an average step rate of rpm*STEPS_PER_REV/60 per second with no drift.
    localparam logic [32:0] ACC_LIMIT  = 33'(64'(CLK_HZ) * 64'd60);
    localparam logic [32:0] STEP_INC   = 33'(STEPS_PER_REV);
    localparam logic [6:0]  RPM_CLAMP  = 7'(RPM_MAX);
    localparam logic [31:0] RAMP_LAST  = 32'(RAMP_TICKS - 1);
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_W - 1);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_ACCEL,
        ST_RUN,
        ST_DECEL,
        ST_REVERSE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  target_q, target_d;
    logic        target_dir_q, target_dir_d;
    logic        kier_q, kier_d;
    logic [6:0]  rpm_q, rpm_d;
    logic [32:0] acc_q, acc_d;
    logic        krok_q, krok_d;
    logic [31:0] pulse_cnt_q, pulse_cnt_d;
    logic [31:0] ramp_cnt_q, ramp_cnt_d;
    logic [31:0] rev_cnt_q, rev_cnt_d;
    logic        rev_flipped_q, rev_flipped_d;
    logic        w_ruchu_q, w_ruchu_d;
    logic        gotowy_q, gotowy_d;

    logic        dir_mismatch;
    logic [6:0]  goal;
    logic        ramp_pending;
    logic        ramp_tick;
    logic [32:0] acc_sum;
    logic        step_due;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        target_dir_d  = target_dir_q;
        kier_d        = kier_q;
        rpm_d         = rpm_q;
        acc_d         = acc_q;
        krok_d        = krok_q;
        pulse_cnt_d   = pulse_cnt_q;
        ramp_cnt_d    = ramp_cnt_q;
        rev_cnt_d     = rev_cnt_q;
        rev_flipped_d = rev_flipped_q;
        step_due      = 1'b0;

        if (bus.sygnal_zmiany_rpm) begin
            target_d     = (bus.rpm > RPM_CLAMP) ? RPM_CLAMP : bus.rpm;
            target_dir_d = bus.kierunek;
        end

        // While the direction is wrong the only useful speed is zero.
        dir_mismatch = (target_dir_q != kier_q);
        goal         = dir_mismatch ? 7'd0 : target_q;

        // The timer also runs in the cycle where STOP/RUN hands over to a ramp
        // state, so the first 1-rpm change lands RAMP_TICKS after the strobe.
        ramp_pending = (rpm_q != goal) && (state_q != ST_REVERSE);
        ramp_tick    = ramp_pending && (ramp_cnt_q == RAMP_LAST);
        if (!ramp_pending || ramp_tick) begin
            ramp_cnt_d = '0;
        end else begin
            ramp_cnt_d = ramp_cnt_q + 32'd1;
        end

        case (state_q)
            ST_STOP: begin
                if (target_q != 7'd0) begin
                    if (dir_mismatch) begin
                        state_d       = ST_REVERSE;
                        rev_flipped_d = 1'b0;
                        rev_cnt_d     = '0;
                    end else if (RAMP_EN) begin
                        state_d = ST_ACCEL;
                    end else begin
                        rpm_d   = target_q;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_ACCEL: begin
                if (dir_mismatch || (target_q < rpm_q)) begin
                    state_d = ST_DECEL;
                end else if (target_q == rpm_q) begin
                    state_d = ST_RUN;
                end else if (ramp_tick) begin
                    rpm_d = rpm_q + 7'd1;
                    if ((rpm_q + 7'd1) == target_q) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (RAMP_EN) begin
                    if (dir_mismatch || (target_q < rpm_q)) begin
                        state_d = ST_DECEL;
                    end else if (target_q > rpm_q) begin
                        state_d = ST_ACCEL;
                    end
                end else begin
                    if (dir_mismatch) begin
                        rpm_d         = 7'd0;
                        state_d       = ST_REVERSE;
                        rev_flipped_d = 1'b0;
                        rev_cnt_d     = '0;
                    end else if (target_q != rpm_q) begin
                        rpm_d = target_q;
                        if (target_q == 7'd0) begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end

            ST_DECEL: begin
                if (!dir_mismatch && (target_q > rpm_q)) begin
                    state_d = ST_ACCEL;
                end else if ((rpm_q == goal) || (ramp_tick && ((rpm_q - 7'd1) == goal))) begin
                    if (rpm_q != goal) begin
                        rpm_d = rpm_q - 7'd1;
                    end
                    if (goal != 7'd0) begin
                        state_d = ST_RUN;
                    end else if (dir_mismatch) begin
                        state_d       = ST_REVERSE;
                        rev_flipped_d = 1'b0;
                        rev_cnt_d     = '0;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (ramp_tick) begin
                    rpm_d = rpm_q - 7'd1;
                end
            end

            ST_REVERSE: begin
                rpm_d = 7'd0;
                if (!rev_flipped_q) begin
                    // Never flip the direction line under a step pulse.
                    if (!krok_q) begin
                        kier_d        = target_dir_q;
                        rev_flipped_d = 1'b1;
                        rev_cnt_d     = '0;
                    end
                end else if (rev_cnt_q == PULSE_LAST) begin
                    rev_flipped_d = 1'b0;
                    if (target_dir_q != kier_q) begin
                        state_d = ST_REVERSE;
                    end else if (target_q == 7'd0) begin
                        state_d = ST_STOP;
                    end else if (RAMP_EN) begin
                        state_d = ST_ACCEL;
                    end else begin
                        rpm_d   = target_q;
                        state_d = ST_RUN;
                    end
                end else begin
                    rev_cnt_d = rev_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_STOP;
            end
        endcase

        // Step accumulator; held at zero whenever the motor is, or is about to be, stopped.
        acc_sum = acc_q + (33'(rpm_q) * STEP_INC);
        if ((rpm_q == 7'd0) || (rpm_d == 7'd0)) begin
            acc_d = '0;
        end else if (acc_sum >= ACC_LIMIT) begin
            acc_d    = acc_sum - ACC_LIMIT;
            step_due = 1'b1;
        end else begin
            acc_d = acc_sum;
        end

        if (krok_q) begin
            if (pulse_cnt_q == PULSE_LAST) begin
                krok_d = 1'b0;
            end else begin
                pulse_cnt_d = pulse_cnt_q + 32'd1;
            end
        end
        if (step_due) begin
            krok_d      = 1'b1;
            pulse_cnt_d = '0;
        end

        w_ruchu_d = (rpm_d != 7'd0);
        gotowy_d  = (rpm_d == target_d) && (kier_d == target_dir_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_STOP;
            target_q      <= '0;
            target_dir_q  <= 1'b0;
            kier_q        <= 1'b0;
            rpm_q         <= '0;
            acc_q         <= '0;
            krok_q        <= 1'b0;
            pulse_cnt_q   <= '0;
            ramp_cnt_q    <= '0;
            rev_cnt_q     <= '0;
            rev_flipped_q <= 1'b0;
            w_ruchu_q     <= 1'b0;
            gotowy_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            target_dir_q  <= target_dir_d;
            kier_q        <= kier_d;
            rpm_q         <= rpm_d;
            acc_q         <= acc_d;
            krok_q        <= krok_d;
            pulse_cnt_q   <= pulse_cnt_d;
            ramp_cnt_q    <= ramp_cnt_d;
            rev_cnt_q     <= rev_cnt_d;
            rev_flipped_q <= rev_flipped_d;
            w_ruchu_q     <= w_ruchu_d;
            gotowy_q      <= gotowy_d;
        end
    end

    assign bus.krok        = krok_q;
    assign bus.kier        = kier_q;
    assign bus.biezace_rpm = rpm_q;
    assign bus.w_ruchu     = w_ruchu_q;
    assign bus.gotowy      = gotowy_q;

endmodule
